// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file write-back buffer with in-order drain and forwarding
module regfile_wb_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         nRst,
    input  logic                         wb0_valid,
    input  logic [4:0]                   wb0_wsel,
    input  logic [31:0]                  wb0_wdat,
    output logic                         wb0_ready,
    input  logic                         wb1_valid,
    input  logic [4:0]                   wb1_wsel,
    input  logic [31:0]                  wb1_wdat,
    output logic                         wb1_ready,
    output logic                         WEN,
    output logic [4:0]                   wsel,
    output logic [31:0]                  wdat,
    input  logic [4:0]                   fwd_rsel1,
    input  logic [4:0]                   fwd_rsel2,
    output logic                         fwd_hit1,
    output logic                         fwd_hit2,
    output logic [31:0]                  fwd_dat1,
    output logic [31:0]                  fwd_dat2,
    output logic [31:0]                  busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [4:0]       r_sel [DEPTH];
    logic [31:0]      r_dat [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_ready;
    logic             w_drain;
    logic             w_acc0;
    logic             w_acc1;
    logic [PTR_W-1:0] w_slot0;
    logic [DEPTH-1:0] w_live;
    logic [4:0]       w_age_sel [DEPTH];
    logic [31:0]      w_age_dat [DEPTH];

    // Two slots must be free so a dual accept can never overflow; no drain credit is taken.
    assign w_ready = (r_count <= CNT_W'(DEPTH-2));
    assign w_drain = (r_count != '0);
    assign w_acc1  = wb1_valid && w_ready && (wb1_wsel != 5'd0);
    assign w_acc0  = wb0_valid && w_ready && (wb0_wsel != 5'd0);
    assign w_slot0 = r_tail + PTR_W'(w_acc1);

    // Entries viewed by age: index 0 is the head (oldest).
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        logic [PTR_W-1:0] w_idx;
        assign w_idx        = r_head + PTR_W'(g);
        assign w_live[g]    = (CNT_W'(g) < r_count);
        assign w_age_sel[g] = r_sel[w_idx];
        assign w_age_dat[g] = r_dat[w_idx];
    end

    always_ff @(posedge CLK or negedge nRst) begin
        if (!nRst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_sel[i] <= '0;
                r_dat[i] <= '0;
            end
        end else begin
            // wb1 is the older instruction, so it takes the first free slot.
            if (w_acc1) begin
                r_sel[r_tail] <= wb1_wsel;
                r_dat[r_tail] <= wb1_wdat;
            end
            if (w_acc0) begin
                r_sel[w_slot0] <= wb0_wsel;
                r_dat[w_slot0] <= wb0_wdat;
            end
            r_tail  <= r_tail + PTR_W'(w_acc1) + PTR_W'(w_acc0);
            r_head  <= r_head + PTR_W'(w_drain);
            r_count <= r_count - CNT_W'(w_drain) + CNT_W'(w_acc1) + CNT_W'(w_acc0);
        end
    end

    assign WEN       = w_drain;
    assign wsel      = w_drain ? w_age_sel[0] : 5'd0;
    assign wdat      = w_drain ? w_age_dat[0] : 32'd0;
    assign wb0_ready = w_ready;
    assign wb1_ready = w_ready;
    assign count     = r_count;
    assign idle      = (r_count == '0);

    // Scanning oldest to youngest lets the last match win, giving youngest-wins forwarding.
    always_comb begin
        fwd_hit1 = 1'b0;
        fwd_hit2 = 1'b0;
        fwd_dat1 = 32'd0;
        fwd_dat2 = 32'd0;
        busy     = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i]) begin
                busy[w_age_sel[i]] = 1'b1;
                if ((fwd_rsel1 != 5'd0) && (w_age_sel[i] == fwd_rsel1)) begin
                    fwd_hit1 = 1'b1;
                    fwd_dat1 = w_age_dat[i];
                end
                if ((fwd_rsel2 != 5'd0) && (w_age_sel[i] == fwd_rsel2)) begin
                    fwd_hit2 = 1'b1;
                    fwd_dat2 = w_age_dat[i];
                end
            end
        end
        busy[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic              CLK = 1'b0;
    logic              nRst;
    logic              wb0_valid, wb1_valid;
    logic [4:0]        wb0_wsel, wb1_wsel;
    logic [31:0]       wb0_wdat, wb1_wdat;
    logic              wb0_ready, wb1_ready;
    logic              WEN;
    logic [4:0]        wsel;
    logic [31:0]       wdat;
    logic [4:0]        fwd_rsel1, fwd_rsel2;
    logic              fwd_hit1, fwd_hit2;
    logic [31:0]       fwd_dat1, fwd_dat2;
    logic [31:0]       busy;
    logic [CNT_W-1:0]  count;
    logic              idle;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRst(nRst),
        .wb0_valid(wb0_valid), .wb0_wsel(wb0_wsel), .wb0_wdat(wb0_wdat), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_wsel(wb1_wsel), .wb1_wdat(wb1_wdat), .wb1_ready(wb1_ready),
        .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .fwd_rsel1(fwd_rsel1), .fwd_rsel2(fwd_rsel2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_dat1(fwd_dat1), .fwd_dat2(fwd_dat2),
        .busy(busy), .count(count), .idle(idle)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in;
        wb0_valid = 1'b0; wb0_wsel = 5'd0; wb0_wdat = 32'd0;
        wb1_valid = 1'b0; wb1_wsel = 5'd0; wb1_wdat = 32'd0;
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        clear_in();
        fwd_rsel1 = 5'd0;
        fwd_rsel2 = 5'd0;
        repeat (2) tick();
        checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", WEN); end
        checks++; if (wsel !== 5'd0 || wdat !== 32'd0) begin errors++; $display("FAIL reset_wsel_wdat: got %0d/%h expected 0/0", wsel, wdat); end
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
        checks++; if (idle !== 1'b1 || count !== '0) begin errors++; $display("FAIL reset_idle_count: got %0b/%0d expected 1/0", idle, count); end
        checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b/%0b expected 1/1", wb0_ready, wb1_ready); end
        checks++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || fwd_dat1 !== 32'd0 || fwd_dat2 !== 32'd0) begin errors++; $display("FAIL reset_fwd: got %0b %0b %h %h expected 0 0 0 0", fwd_hit1, fwd_hit2, fwd_dat1, fwd_dat2); end
        nRst = 1'b1;
        tick();
        checks++; if (idle !== 1'b1 || WEN !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got idle=%0b wen=%0b expected 1/0", idle, WEN); end
    endtask

    task automatic test_single_write;
        wb0_valid = 1'b1; wb0_wsel = 5'd5; wb0_wdat = 32'hDEADBEEF;
        fwd_rsel1 = 5'd5;
        #1;
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b expected 1", wb0_ready); end
        checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL single_same_cycle_fwd: got %0b expected 0", fwd_hit1); end
        tick();
        clear_in();
        checks++; if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL single_write: got %0b/%0d/%h expected 1/5/deadbeef", WEN, wsel, wdat); end
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL single_busy: got %h expected 00000020", busy); end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_dat1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_fwd: got %0b/%h expected 1/deadbeef", fwd_hit1, fwd_dat1); end
        tick();
        checks++; if (idle !== 1'b1 || busy !== 32'd0 || WEN !== 1'b0) begin errors++; $display("FAIL single_drained: got idle=%0b busy=%h wen=%0b expected 1/0/0", idle, busy, WEN); end
        fwd_rsel1 = 5'd0;
    endtask

    task automatic test_ordering;
        wb1_valid = 1'b1; wb1_wsel = 5'd3; wb1_wdat = 32'h11;
        wb0_valid = 1'b1; wb0_wsel = 5'd3; wb0_wdat = 32'h22;
        fwd_rsel1 = 5'd3; fwd_rsel2 = 5'd3;
        tick();
        clear_in();
        checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL order_count: got %0d expected 2", count); end
        checks++; if (WEN !== 1'b1 || wsel !== 5'd3 || wdat !== 32'h11) begin errors++; $display("FAIL order_first: got %0b/%0d/%h expected 1/3/11", WEN, wsel, wdat); end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_dat1 !== 32'h22 || fwd_hit2 !== 1'b1 || fwd_dat2 !== 32'h22) begin errors++; $display("FAIL order_fwd_youngest: got %0b/%h %0b/%h expected 1/22 1/22", fwd_hit1, fwd_dat1, fwd_hit2, fwd_dat2); end
        tick();
        checks++; if (WEN !== 1'b1 || wsel !== 5'd3 || wdat !== 32'h22) begin errors++; $display("FAIL order_second: got %0b/%0d/%h expected 1/3/22", WEN, wsel, wdat); end
        checks++; if (fwd_hit1 !== 1'b1 || fwd_dat1 !== 32'h22) begin errors++; $display("FAIL order_fwd_head: got %0b/%h expected 1/22", fwd_hit1, fwd_dat1); end
        tick();
        checks++; if (idle !== 1'b1 || fwd_hit1 !== 1'b0 || fwd_dat1 !== 32'd0) begin errors++; $display("FAIL order_drained: got idle=%0b hit=%0b dat=%h expected 1/0/0", idle, fwd_hit1, fwd_dat1); end
        fwd_rsel1 = 5'd0; fwd_rsel2 = 5'd0;
    endtask

    task automatic test_zero_reg;
        int wen_seen;
        wen_seen = 0;
        wb0_valid = 1'b1; wb0_wsel = 5'd0; wb0_wdat = 32'hFFFF_FFFF;
        fwd_rsel1 = 5'd0;
        #1;
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", wb0_ready); end
        tick();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            if (WEN !== 1'b0) wen_seen++;
            tick();
        end
        checks++; if (wen_seen != 0) begin errors++; $display("FAIL zero_wen: got %0d WEN cycles expected 0", wen_seen); end
        checks++; if (count !== '0 || fwd_hit1 !== 1'b0) begin errors++; $display("FAIL zero_count_fwd: got %0d/%0b expected 0/0", count, fwd_hit1); end
    endtask

    task automatic test_back_pressure;
        logic [36:0] q[$];
        int pair;
        int cyc;
        logic exp_rdy;
        pair = 0;
        cyc  = 0;
        while ((pair < 6 || q.size() > 0) && cyc < 60) begin
            if (pair < 6) begin
                wb1_valid = 1'b1; wb1_wsel = 5'(2*pair+1); wb1_wdat = 32'hA000_0000 | 32'(2*pair+1);
                wb0_valid = 1'b1; wb0_wsel = 5'(2*pair+2); wb0_wdat = 32'hA000_0000 | 32'(2*pair+2);
            end else begin
                clear_in();
            end
            exp_rdy = (q.size() <= DEPTH-2);
            #1;
            checks++; if (wb0_ready !== exp_rdy || wb1_ready !== exp_rdy) begin errors++; $display("FAIL bp_ready cyc%0d: got %0b/%0b expected %0b", cyc, wb0_ready, wb1_ready, exp_rdy); end
            checks++; if (count !== CNT_W'(q.size())) begin errors++; $display("FAIL bp_count cyc%0d: got %0d expected %0d", cyc, count, q.size()); end
            if (q.size() > 0) begin
                checks++; if (WEN !== 1'b1 || {wsel, wdat} !== q[0]) begin errors++; $display("FAIL bp_drain cyc%0d: got %0b/%0d/%h expected 1/%0d/%h", cyc, WEN, wsel, wdat, q[0][36:32], q[0][31:0]); end
            end else begin
                checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL bp_idle cyc%0d: got %0b expected 0", cyc, WEN); end
            end
            tick();
            if (q.size() > 0) void'(q.pop_front());
            if (pair < 6 && exp_rdy) begin
                q.push_back({5'(2*pair+1), 32'hA000_0000 | 32'(2*pair+1)});
                q.push_back({5'(2*pair+2), 32'hA000_0000 | 32'(2*pair+2)});
                pair++;
            end
            checks++; if (count > CNT_W'(DEPTH)) begin errors++; $display("FAIL bp_overflow cyc%0d: got %0d expected <= %0d", cyc, count, DEPTH); end
            cyc++;
        end
        clear_in();
        checks++; if (cyc >= 60) begin errors++; $display("FAIL bp_timeout: got %0d cycles expected < 60", cyc); end
    endtask

    task automatic test_wrap_around;
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1) begin
                wb0_valid = 1'b1; wb0_wsel = 5'(i); wb0_wdat = 32'h100 + 32'(i);
            end else begin
                wb1_valid = 1'b1; wb1_wsel = 5'(i); wb1_wdat = 32'h100 + 32'(i);
            end
            tick();
            clear_in();
            checks++; if (WEN !== 1'b1 || wsel !== 5'(i) || wdat !== 32'h100 + 32'(i)) begin errors++; $display("FAIL wrap_write%0d: got %0b/%0d/%h expected 1/%0d/%h", i, WEN, wsel, wdat, i, 32'h100 + 32'(i)); end
            tick();
            checks++; if (WEN !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL wrap_gap%0d: got wen=%0b idle=%0b expected 0/1", i, WEN, idle); end
        end
    endtask

    task automatic test_mid_reset;
        int wen_seen;
        wen_seen = 0;
        wb1_valid = 1'b1; wb1_wsel = 5'd7;  wb1_wdat = 32'h70;
        wb0_valid = 1'b1; wb0_wsel = 5'd8;  wb0_wdat = 32'h80;
        tick();
        wb1_valid = 1'b1; wb1_wsel = 5'd9;  wb1_wdat = 32'h90;
        wb0_valid = 1'b1; wb0_wsel = 5'd10; wb0_wdat = 32'hA0;
        tick();
        clear_in();
        fwd_rsel1 = 5'd9;
        #1;
        checks++; if (count !== CNT_W'(3) || wsel !== 5'd8 || fwd_hit1 !== 1'b1) begin errors++; $display("FAIL mid_prefill: got count=%0d wsel=%0d hit=%0b expected 3/8/1", count, wsel, fwd_hit1); end
        #1;
        nRst = 1'b0;
        #1;
        checks++; if (count !== '0 || idle !== 1'b1) begin errors++; $display("FAIL mid_reset_count: got %0d/%0b expected 0/1", count, idle); end
        checks++; if (WEN !== 1'b0 || wsel !== 5'd0 || wdat !== 32'd0) begin errors++; $display("FAIL mid_reset_wr: got %0b/%0d/%h expected 0/0/0", WEN, wsel, wdat); end
        checks++; if (busy !== 32'd0 || fwd_hit1 !== 1'b0 || fwd_dat1 !== 32'd0) begin errors++; $display("FAIL mid_reset_fwd: got busy=%h hit=%0b dat=%h expected 0/0/0", busy, fwd_hit1, fwd_dat1); end
        checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %0b/%0b expected 1/1", wb0_ready, wb1_ready); end
        #1;
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (WEN !== 1'b0) wen_seen++;
        end
        checks++; if (wen_seen != 0) begin errors++; $display("FAIL mid_reset_no_wen: got %0d WEN cycles expected 0", wen_seen); end
        wb0_valid = 1'b1; wb0_wsel = 5'd4; wb0_wdat = 32'h44;
        tick();
        clear_in();
        checks++; if (WEN !== 1'b1 || wsel !== 5'd4 || wdat !== 32'h44) begin errors++; $display("FAIL mid_reset_resume: got %0b/%0d/%h expected 1/4/44", WEN, wsel, wdat); end
        tick();
        fwd_rsel1 = 5'd0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_ordering();
        test_zero_reg();
        test_back_pressure();
        test_wrap_around();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: write-buffer entries; power of two, minimum 2.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 nRst  input  1  asynchronous, active-low reset.
REQ-004 wb0_valid  input  1  execute-stage write request.
REQ-005 wb0_wsel  input  5  execute-stage destination register.
REQ-006 wb0_wdat  input  32  execute-stage write data.
REQ-007 wb0_ready  output  1  execute-stage request accepted this cycle when high with wb0_valid.
REQ-008 wb1_valid, wb1_wsel, wb1_wdat, wb1_ready  in/in/in/out  1/5/32/1  memory-stage (load) write request; same meaning as wb0.
REQ-009 WEN  output  1  register-file write enable.
REQ-010 wsel  output  5  register-file write select.
REQ-011 wdat  output  32  register-file write data.
REQ-012 fwd_rsel1, fwd_rsel2  input  5 each  forwarding lookup selects.
REQ-013 fwd_hit1, fwd_hit2  output  1 each  lookup matched a buffered write.
REQ-014 fwd_dat1, fwd_dat2  output  32 each  data of the youngest matching buffered write.
REQ-015 busy  output  32  bit n high when any buffered entry targets register n; bit 0 always 0.
REQ-016 count  output  $clog2(DEPTH+1)  number of buffered entries.
REQ-017 idle  output  1  high when count == 0.

Function
REQ-018 Circular FIFO of DEPTH entries {wsel, wdat}; head/tail pointers wrap modulo DEPTH.
REQ-019 wb0_ready = wb1_ready = (count <= DEPTH-2), from registered count only; no same-cycle drain credit.
REQ-020 Accepted request: valid && ready at rising edge.
REQ-021 Both accepted in one cycle: wb1 (older instruction) enqueued before wb0.
REQ-022 Accepted request with wsel == 0: handshake completes, nothing enqueued.
REQ-023 Drain: when count > 0, WEN = 1, wsel/wdat = head entry (combinational from registered state); head pops at the next rising edge.
REQ-024 count == 0: WEN = 0, wsel = 0, wdat = 0.
REQ-025 Next count = count - (drain ? 1 : 0) + number of nonzero-wsel accepts; never exceeds DEPTH.
REQ-026 Latency: entry accepted at edge N into an empty buffer drives WEN in cycle N+1; one write per cycle, FIFO order.
REQ-027 Forwarding: fwd_hitK = 1 when fwd_rselK != 0 and matches any valid entry, head included; fwd_datK = youngest matching entry's wdat; otherwise hit = 0, dat = 0.
REQ-028 Forwarding and busy are combinational from stored entries only; same-cycle incoming requests are not visible.
REQ-029 Duplicate destinations allowed; all entries written in order; forwarding returns the youngest.
REQ-030 busy recomputed every cycle from valid entries; a bit clears the cycle after its last matching entry drains.

Reset
REQ-031 nRst low: count = 0, head = tail = 0, all entries invalid, immediately and regardless of CLK.
REQ-032 During and after reset: WEN = 0, wsel = 0, wdat = 0, busy = 0, fwd_hit1/2 = 0, fwd_dat1/2 = 0, idle = 1, wb0_ready = wb1_ready = 1.
REQ-033 Reset during operation discards all buffered writes; no WEN pulse is issued for them.

Verification
REQ-034 Single write: wb0 {wsel=5, wdat=0xDEADBEEF} one cycle -> next cycle WEN=1, wsel=5, wdat=0xDEADBEEF, busy[5]=1; following cycle idle=1, busy=0.
REQ-035 Ordering: wb1 {3, 0x11} and wb0 {3, 0x22} same cycle -> writes 0x11 then 0x22 on consecutive cycles; fwd_rsel1=3 returns 0x22 with hit=1 while both buffered.
REQ-036 Zero register: wb0 {0, 0xFFFF_FFFF} -> wb0_ready=1, count stays 0, WEN never asserted, fwd_rsel1=0 -> hit=0.
REQ-037 Back-pressure: DEPTH=4, dual requests to distinct registers each cycle -> ready drops when count=3, count never exceeds 4, all writes appear in wb1-before-wb0 order with none lost.
REQ-038 Wrap-around: 10 single requests wsel=1..10 interleaved with idle cycles -> pointers wrap, writes emerge in order 1..10 with matching data.
REQ-039 Mid-operation reset: count=3, nRst pulsed low between clock edges -> outputs at REQ-032 values immediately; no further WEN until new requests.
